piso_serializer: RTL and testbench



---
 rtl/piso_serializer_if.sv | 28 ++
 rtl/piso_serializer.sv | 86 ++++++++
 tb/tb_piso_serializer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// Load handshake and serial-output bundle for piso_serializer.
// The master side is the upstream/downstream environment, the slave side
// is the serializer itself.
interface piso_serializer_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
);
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_data;
   logic             msb_first;
   logic             shift_en;
   logic             sout;
   logic             sout_valid;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] bit_idx;

   modport master (
      output load_valid, load_data, msb_first, shift_en,
      input  load_ready, sout, sout_valid, busy, done, bit_idx
   );

   modport slave (
      input  load_valid, load_data, msb_first, shift_en,
      output load_ready, sout, sout_valid, busy, done, bit_idx
   );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out shift register. Accepts a word over a
// valid/ready handshake, then emits it one bit per enabled clock, MSB- or
// LSB-first, followed by a one-cycle done pulse.
module piso_serializer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   piso_serializer_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_shreg;
   logic [CNT_W-1:0] r_bit_idx;
   logic             r_msb_first;

   logic             w_in_shift;
   logic             w_head_bit;

   // FSM, shift register and bit counter; reset discards any word in flight
   always_ff @(posedge clk) begin
      // NOTE: all state here uses non-blocking assignments so every register
      // samples the pre-edge values of the others, whatever the statement order.
      if (reset) begin
         r_state     <= S_IDLE;
         r_shreg     <= '0;
         r_bit_idx   <= '0;
         r_msb_first <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.load_valid) begin
                  r_shreg     <= bus.load_data;
                  r_msb_first <= bus.msb_first;
                  r_bit_idx   <= '0;
                  r_state     <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (bus.shift_en) begin
                  // Move the next bit toward whichever end drives sout
                  if (r_msb_first) begin
                     r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
                  end else begin
                     r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
                  end
                  if (r_bit_idx == LAST_IDX) begin
                     r_bit_idx <= '0;
                     r_state   <= S_DONE;
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // NOTE: outputs are plain continuous decodes of registered state, so no
   // procedural block exists that could leave a path unassigned and infer a latch.
   assign w_in_shift = (r_state == S_SHIFT);
   assign w_head_bit = r_msb_first ? r_shreg[WIDTH-1] : r_shreg[0];

   assign bus.load_ready = (r_state == S_IDLE);
   assign bus.busy       = (r_state != S_IDLE);
   assign bus.done       = (r_state == S_DONE);
   assign bus.sout       = w_in_shift & w_head_bit;
   assign bus.sout_valid = w_in_shift & bus.shift_en;
   assign bus.bit_idx    = r_bit_idx;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: reset, both shift orders, stalls,
// back-to-back loads and reset in mid-word.
module tb_piso_serializer;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;
   int   cyc;
   int   k1;

   piso_serializer_if #(.WIDTH(8), .CNT_W(3)) bus ();

   piso_serializer #(.WIDTH(8), .CNT_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".load_ready"}, 32'(bus.load_ready), 32'd1);
      check({tag, ".sout"},       32'(bus.sout),       32'd0);
      check({tag, ".sout_valid"}, 32'(bus.sout_valid), 32'd0);
      check({tag, ".busy"},       32'(bus.busy),       32'd0);
      check({tag, ".done"},       32'(bus.done),       32'd0);
      check({tag, ".bit_idx"},    32'(bus.bit_idx),    32'd0);
   endtask

   // Called in the first SHIFT cycle with shift_en=1 held; checks the
   // 8 bits, the done cycle and the return of load_ready.
   task automatic run_stream(input string tag, input logic [0:7] s);
      for (int i = 0; i < 8; i++) begin
         #1;
         check($sformatf("%s.sout[%0d]", tag, i),    32'(bus.sout),       32'(s[i]));
         check($sformatf("%s.valid[%0d]", tag, i),   32'(bus.sout_valid), 32'd1);
         check($sformatf("%s.idx[%0d]", tag, i),     32'(bus.bit_idx),    32'(i));
         check($sformatf("%s.ready[%0d]", tag, i),   32'(bus.load_ready), 32'd0);
         check($sformatf("%s.done[%0d]", tag, i),    32'(bus.done),       32'd0);
         step();
      end
      #1;
      check({tag, ".done_pulse"},  32'(bus.done),       32'd1);
      check({tag, ".done_busy"},   32'(bus.busy),       32'd1);
      check({tag, ".done_valid"},  32'(bus.sout_valid), 32'd0);
      check({tag, ".done_sout"},   32'(bus.sout),       32'd0);
      check({tag, ".done_ready"},  32'(bus.load_ready), 32'd0);
      step();
      #1;
      check({tag, ".ready_back"},  32'(bus.load_ready), 32'd1);
      check({tag, ".done_clear"},  32'(bus.done),       32'd0);
      check({tag, ".busy_clear"},  32'(bus.busy),       32'd0);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      cyc     = 0;

      // Reset held two cycles while upstream offers 8'hFF
      reset          = 1'b1;
      bus.load_valid = 1'b1;
      bus.load_data  = 8'hFF;
      bus.msb_first  = 1'b1;
      bus.shift_en   = 1'b1;
      step();
      step();
      #1;
      check_idle("reset");
      reset          = 1'b0;
      bus.load_valid = 1'b0;
      step();
      #1;
      check_idle("post_reset");
      step();
      #1;
      check_idle("idle_shift_en");

      // MSB-first 8'h1E
      bus.load_valid = 1'b1;
      bus.load_data  = 8'h1E;
      bus.msb_first  = 1'b1;
      bus.shift_en   = 1'b1;
      step();
      bus.load_valid = 1'b0;
      bus.load_data  = 8'h00;
      run_stream("msb_1e", 8'b00011110);

      // LSB-first 8'h1E, order input flipped right after acceptance
      bus.load_valid = 1'b1;
      bus.load_data  = 8'h1E;
      bus.msb_first  = 1'b0;
      step();
      bus.load_valid = 1'b0;
      bus.msb_first  = 1'b1;
      run_stream("lsb_1e", 8'b01111000);

      // Stall: MSB-first 8'hA5, 3 idle cycles after 2 bits
      bus.load_valid = 1'b1;
      bus.load_data  = 8'hA5;
      bus.msb_first  = 1'b1;
      bus.shift_en   = 1'b1;
      step();
      k1 = cyc;
      bus.load_valid = 1'b0;
      #1;
      check("stall.b0", 32'(bus.sout), 32'd1);
      step();
      #1;
      check("stall.b1", 32'(bus.sout), 32'd0);
      step();
      bus.shift_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("stall.hold_sout[%0d]", i),  32'(bus.sout),       32'd1);
         check($sformatf("stall.hold_valid[%0d]", i), 32'(bus.sout_valid), 32'd0);
         check($sformatf("stall.hold_idx[%0d]", i),   32'(bus.bit_idx),    32'd2);
         check($sformatf("stall.hold_busy[%0d]", i),  32'(bus.busy),       32'd1);
         step();
      end
      bus.shift_en = 1'b1;
      begin
         logic [0:5] rest;
         rest = 6'b100101;
         for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("stall.sout[%0d]", i + 2),  32'(bus.sout),       32'(rest[i]));
            check($sformatf("stall.valid[%0d]", i + 2), 32'(bus.sout_valid), 32'd1);
            check($sformatf("stall.idx[%0d]", i + 2),   32'(bus.bit_idx),    32'(i + 2));
            step();
         end
      end
      #1;
      check("stall.done", 32'(bus.done), 32'd1);
      check("stall.done_cycle", 32'(cyc - k1), 32'd11);
      step();
      #1;
      check("stall.ready_back", 32'(bus.load_ready), 32'd1);

      // Back-to-back: load_valid held, 8'h81 then 8'h7E
      bus.load_valid = 1'b1;
      bus.load_data  = 8'h81;
      bus.msb_first  = 1'b1;
      step();
      bus.load_data  = 8'h7E;
      run_stream("b2b_81", 8'b10000001);
      step();
      bus.load_valid = 1'b0;
      run_stream("b2b_7e", 8'b01111110);

      // Reset after 4 bits of 8'hF0
      bus.load_valid = 1'b1;
      bus.load_data  = 8'hF0;
      bus.msb_first  = 1'b1;
      step();
      bus.load_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("rst_mid.sout[%0d]", i), 32'(bus.sout), 32'd1);
         step();
      end
      #1;
      check("rst_mid.idx4", 32'(bus.bit_idx), 32'd4);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      check_idle("rst_mid");
      for (int i = 0; i < 6; i++) begin
         step();
         #1;
         check($sformatf("rst_mid.no_done[%0d]", i), 32'(bus.done), 32'd0);
      end
      bus.load_valid = 1'b1;
      bus.load_data  = 8'h0F;
      bus.msb_first  = 1'b1;
      step();
      bus.load_valid = 1'b0;
      run_stream("fresh_0f", 8'b00001111);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
